// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP word, fetch FSM
// state encoding, default reset PC and the jump-target helper.
package mips_pkg;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_t;

  // Jump destination: top nibble of the decode-stage PC+4, word index, byte offset 0.
  function automatic logic [31:0] jump_target(input logic [3:0]  pc_hi,
                                              input logic [25:0] index);
    return {pc_hi, index, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage
// (master) and the instruction memory (slave).
interface ifetch_if #(
  parameter int MIP_BUS = 32
);
  logic               imem_req;
  logic [MIP_BUS-1:0] imem_addr;
  logic               imem_ack;
  logic [MIP_BUS-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC select: branch beats jump, jump beats sequential
// advance, otherwise the PC holds. Result is always word aligned.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter int MIP_BUS = 32
) (
  input  logic [MIP_BUS-1:0] i_pc,
  input  logic [3:0]         i_pc_hi,
  input  logic               i_advance,
  input  logic               i_branch_taken,
  input  logic [MIP_BUS-1:0] i_branch_target,
  input  logic               i_jump,
  input  logic [25:0]        i_jump_index,
  output logic [MIP_BUS-1:0] o_next_pc,
  output logic               o_redirect
);

  logic [MIP_BUS-1:0] w_sel;

  // Priority mux over the four next-PC sources.
  always_comb begin
    w_sel      = i_pc;
    o_redirect = i_branch_taken | i_jump;
    if (i_branch_taken) begin
      w_sel = i_branch_target;
    end else if (i_jump) begin
      w_sel = jump_target(i_pc_hi, i_jump_index);
    end else if (i_advance) begin
      w_sel = i_pc + MIP_BUS'(4);
    end
    o_next_pc = w_sel & ~MIP_BUS'(3);
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, memory request FSM and IF/ID register.
// Optional build macro IFETCH_PREFETCH_BUF_EN adds a one-entry buffer that
// keeps a word acknowledged under stall (HOLD state); without it such a word
// is dropped and the same address is requested again.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | request for PC outstanding on the bus
// S_HOLD  | acknowledged word parked in the buffer while decode stalls
// S_DRAIN | waiting out a stale request after a redirect; its ack is dropped
module ifetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          MIP_BUS  = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [MIP_BUS-1:0] branch_target,
  input  logic               Jump,
  input  logic [25:0]        jump_index,
  ifetch_if.master           imem,
  output logic [MIP_BUS-1:0] Instruction,
  output logic [MIP_BUS-1:0] PC_plus4,
  output logic               if_valid
);

  fetch_state_t       r_state;
  logic [MIP_BUS-1:0] r_pc;
  logic [MIP_BUS-1:0] r_drain_addr;
  logic [MIP_BUS-1:0] r_instr;
  logic [MIP_BUS-1:0] r_pc_plus4;
  logic               r_valid;
`ifdef IFETCH_PREFETCH_BUF_EN
  logic [MIP_BUS-1:0] r_buf;
`endif

  logic [MIP_BUS-1:0] w_pc_plus4;
  logic [MIP_BUS-1:0] w_next_pc;
  logic [MIP_BUS-1:0] w_addr;
  logic               w_redirect;
  logic               w_advance;

  assign w_pc_plus4 = r_pc + MIP_BUS'(4);

  // The PC moves on when a word is delivered into IF/ID, either straight
  // from the bus or out of the hold buffer.
  assign w_advance = ((r_state == S_FETCH) && imem.imem_ack && !stall) ||
                     ((r_state == S_HOLD) && !stall);

  pc_next_sel #(
    .MIP_BUS (MIP_BUS)
  ) u_pc_next_sel (
    .i_pc            (r_pc),
    .i_pc_hi         (r_pc_plus4[MIP_BUS-1:MIP_BUS-4]),
    .i_advance       (w_advance),
    .i_branch_taken  (branch_taken),
    .i_branch_target (branch_target),
    .i_jump          (Jump),
    .i_jump_index    (jump_index),
    .o_next_pc       (w_next_pc),
    .o_redirect      (w_redirect)
  );

  // Bus outputs: a stale request keeps its original address until acked.
  assign w_addr         = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
  assign imem.imem_addr = w_addr & ~MIP_BUS'(3);
  assign imem.imem_req  = !rst && (r_state != S_HOLD);

  assign Instruction = r_instr;
  assign PC_plus4    = r_pc_plus4;
  assign if_valid    = r_valid;

  // Fetch FSM, PC register and IF/ID register; a redirect outranks stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_drain_addr <= '0;
      r_instr      <= NOP_WORD;
      r_pc_plus4   <= '0;
      r_valid      <= 1'b0;
`ifdef IFETCH_PREFETCH_BUF_EN
      r_buf        <= NOP_WORD;
`endif
    end else begin
      r_pc <= w_next_pc;
      if (w_redirect) begin
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
`ifdef IFETCH_PREFETCH_BUF_EN
        r_buf   <= NOP_WORD;
`endif
        case (r_state)
          S_FETCH: begin
            if (!imem.imem_ack) begin
              r_state      <= S_DRAIN;
              r_drain_addr <= r_pc;
            end
          end
          S_HOLD:  r_state <= S_FETCH;
          S_DRAIN: begin
            if (imem.imem_ack) r_state <= S_FETCH;
          end
          default: r_state <= S_FETCH;
        endcase
      end else begin
        case (r_state)
          S_FETCH: begin
            if (!stall) begin
              if (imem.imem_ack) begin
                r_instr    <= imem.imem_rdata;
                r_pc_plus4 <= w_pc_plus4;
                r_valid    <= 1'b1;
              end else begin
                r_instr <= NOP_WORD;
                r_valid <= 1'b0;
              end
            end
`ifdef IFETCH_PREFETCH_BUF_EN
            else if (imem.imem_ack) begin
              r_buf   <= imem.imem_rdata;
              r_state <= S_HOLD;
            end
`endif
          end
          S_HOLD: begin
`ifdef IFETCH_PREFETCH_BUF_EN
            if (!stall) begin
              r_instr    <= r_buf;
              r_pc_plus4 <= w_pc_plus4;
              r_valid    <= 1'b1;
              r_state    <= S_FETCH;
            end
`else
            r_state <= S_FETCH;
`endif
          end
          S_DRAIN: begin
            if (!stall) begin
              r_instr <= NOP_WORD;
              r_valid <= 1'b0;
            end
            if (imem.imem_ack) r_state <= S_FETCH;
          end
          default: r_state <= S_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Directed, table-driven bench for ifetch. The bench plays instruction memory:
// the ack pattern comes from the table and rdata is the bitwise inverse of
// the requested address, so every expected Instruction is ~address.
module tb_ifetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        Jump;
  logic [25:0] jump_index;
  logic [31:0] Instruction;
  logic [31:0] PC_plus4;
  logic        if_valid;

  ifetch_if #(.MIP_BUS(32)) bus ();

  ifetch dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .Jump          (Jump),
    .jump_index    (jump_index),
    .imem          (bus),
    .Instruction   (Instruction),
    .PC_plus4      (PC_plus4),
    .if_valid      (if_valid)
  );

  always #5 clk = ~clk;

  assign bus.imem_rdata = bus.imem_ack ? ~bus.imem_addr : 32'hDEAD_BEEF;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        jmp;
    logic [25:0] jidx;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        chk_p;
    logic [31:0] e_pcp4;
  } vec_t;

  vec_t vq[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic r, input logic s, input logic b, input logic [31:0] t,
                     input logic j, input logic [25:0] ji, input logic a,
                     input logic er, input logic [31:0] ea, input logic [31:0] ei,
                     input logic ev, input logic cp, input logic [31:0] ep);
    vec_t v;
    v.rst = r; v.stall = s; v.br = b; v.tgt = t; v.jmp = j; v.jidx = ji; v.ack = a;
    v.e_req = er; v.e_addr = ea; v.e_instr = ei; v.e_valid = ev;
    v.chk_p = cp; v.e_pcp4 = ep;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic j, input logic [25:0] ji, input logic a);
    rst = r; stall = s; branch_taken = b; branch_target = t;
    Jump = j; jump_index = ji; bus.imem_ack = a;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0);

    // reset, then one ack per cycle: 0,4,8,C
    add(1,0,0,0,0,0,0, 0,32'h0,32'h0,0,1,32'h0);
    add(0,0,0,0,0,0,1, 1,32'h0,32'h0,0,1,32'h0);
    add(0,0,0,0,0,0,1, 1,32'h4,~32'h0,1,1,32'h4);
    add(0,0,0,0,0,0,1, 1,32'h8,~32'h4,1,1,32'h8);
    add(0,0,0,0,0,0,0, 1,32'hC,~32'h8,1,1,32'hC);
    // ack every third cycle
    add(0,0,0,0,0,0,0, 1,32'hC,32'h0,0,1,32'hC);
    add(0,0,0,0,0,0,1, 1,32'hC,32'h0,0,1,32'hC);
    add(0,0,0,0,0,0,0, 1,32'h10,~32'hC,1,1,32'h10);
    add(0,0,0,0,0,0,0, 1,32'h10,32'h0,0,1,32'h10);
    // stall for 3 cycles while the ack for 0x10 arrives
    add(0,1,0,0,0,0,1, 1,32'h10,32'h0,0,1,32'h10);
`ifdef IFETCH_PREFETCH_BUF_EN
    add(0,1,0,0,0,0,0, 0,32'h0,32'h0,0,1,32'h10);
    add(0,1,0,0,0,0,0, 0,32'h0,32'h0,0,1,32'h10);
    add(0,0,0,0,0,0,0, 0,32'h0,32'h0,0,1,32'h10);
    add(0,0,0,0,0,0,1, 1,32'h14,~32'h10,1,1,32'h14);
    add(0,0,1,32'h20,0,0,1, 1,32'h18,~32'h14,1,1,32'h18);
`else
    add(0,1,0,0,0,0,0, 1,32'h10,32'h0,0,1,32'h10);
    add(0,1,0,0,0,0,0, 1,32'h10,32'h0,0,1,32'h10);
    add(0,0,0,0,0,0,0, 1,32'h10,32'h0,0,1,32'h10);
    add(0,0,0,0,0,0,1, 1,32'h10,32'h0,0,1,32'h10);
    add(0,0,1,32'h20,0,0,1, 1,32'h14,~32'h10,1,1,32'h14);
`endif
    // branch to 0x100 while 0x20 pending: drain, drop its ack
    add(0,0,0,0,0,0,0, 1,32'h20,32'h0,0,0,32'h0);
    add(0,0,1,32'h100,0,0,0, 1,32'h20,32'h0,0,0,32'h0);
    add(0,0,0,0,0,0,0, 1,32'h20,32'h0,0,0,32'h0);
    add(0,0,0,0,0,0,1, 1,32'h20,32'h0,0,0,32'h0);
    add(0,0,0,0,0,0,1, 1,32'h100,32'h0,0,0,32'h0);
    add(0,0,0,0,0,0,0, 1,32'h104,~32'h100,1,1,32'h104);
    // redirects while draining overwrite the PC
    add(0,0,1,32'h200,0,0,0, 1,32'h104,32'h0,0,1,32'h104);
    add(0,0,1,32'h300,0,0,0, 1,32'h104,32'h0,0,1,32'h104);
    add(0,0,0,0,0,0,1, 1,32'h104,32'h0,0,1,32'h104);
    add(0,0,0,0,0,0,1, 1,32'h300,32'h0,0,1,32'h104);
    // redirect with ack in FETCH, then branch+jump+stall together
    add(0,0,1,32'h4000_0004,0,0,1, 1,32'h304,~32'h300,1,1,32'h304);
    add(0,0,0,0,0,0,1, 1,32'h4000_0004,32'h0,0,1,32'h304);
    add(0,1,1,32'h500,1,26'h10,0, 1,32'h4000_0008,~32'h4000_0004,1,1,32'h4000_0008);
    add(0,0,0,0,0,0,1, 1,32'h4000_0008,32'h0,0,1,32'h4000_0008);
    add(0,0,0,0,0,0,0, 1,32'h500,32'h0,0,1,32'h4000_0008);
    // jump alone uses the registered PC_plus4 top nibble
    add(0,0,0,0,1,26'h10,1, 1,32'h500,32'h0,0,1,32'h4000_0008);
    add(0,0,0,0,0,0,1, 1,32'h4000_0040,32'h0,0,1,32'h4000_0008);
    // wrap at the top of the address space, then reset mid-request
    add(0,0,1,32'hFFFF_FFFC,0,0,1, 1,32'h4000_0044,~32'h4000_0040,1,1,32'h4000_0044);
    add(0,0,0,0,0,0,1, 1,32'hFFFF_FFFC,32'h0,0,1,32'h4000_0044);
    add(0,0,0,0,0,0,1, 1,32'h0,~32'hFFFF_FFFC,1,1,32'h0);
    add(1,0,0,0,0,0,0, 0,32'h0,~32'h0,1,1,32'h4);
    add(0,0,0,0,0,0,0, 1,32'h0,32'h0,0,1,32'h0);
    add(0,0,0,0,0,0,1, 1,32'h0,32'h0,0,1,32'h0);
    add(0,0,0,0,0,0,0, 1,32'h4,~32'h0,1,1,32'h4);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].stall, vq[i].br, vq[i].tgt, vq[i].jmp, vq[i].jidx, vq[i].ack);
      #1;
      check($sformatf("v%0d.req", i), {31'h0, bus.imem_req}, {31'h0, vq[i].e_req});
      if (vq[i].e_req) check($sformatf("v%0d.addr", i), bus.imem_addr, vq[i].e_addr);
      check($sformatf("v%0d.instr", i), Instruction, vq[i].e_instr);
      check($sformatf("v%0d.valid", i), {31'h0, if_valid}, {31'h0, vq[i].e_valid});
      if (vq[i].chk_p) check($sformatf("v%0d.pcp4", i), PC_plus4, vq[i].e_pcp4);
    end

    // misaligned branch target: bus address and sequential PC stay word aligned
    @(negedge clk);
    drive(0, 0, 1, 32'h0000_0203, 0, 0, 1);
    #1;
    check("align.pre_addr", bus.imem_addr, 32'h4);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 1);
    #1;
    check("align.addr0", bus.imem_addr, 32'h200);
    check("align.flush", Instruction, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("align.addr1", bus.imem_addr, 32'h204);
    check("align.instr", Instruction, ~32'h200);
    check("align.pcp4", PC_plus4, 32'h204);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter MIP_BUS, 32, datapath width.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 stall  in  1  hazard stall from decode: hold PC and IF/ID register.
REQ-007 branch_taken  in  1  redirect to branch_target this cycle.
REQ-008 branch_target  in  32  branch destination.
REQ-009 Jump  in  1  redirect to jump address this cycle.
REQ-010 jump_index  in  26  Instruction[25:0] of the jump in decode.
REQ-011 imem_req  out  1  fetch request; held high until imem_ack.
REQ-012 imem_addr  out  32  fetch address; stable while imem_req is high.
REQ-013 imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle.
REQ-014 imem_rdata  in  32  fetched word.
REQ-015 Instruction  out  32  IF/ID instruction to decode.
REQ-016 PC_plus4  out  32  IF/ID PC+4 of Instruction.
REQ-017 if_valid  out  1  Instruction is a real fetched word, not a bubble.

Function
REQ-018 States: FETCH (request outstanding), HOLD (word buffered under stall), DRAIN (discarding a stale outstanding request).
REQ-019 FETCH: imem_req=1 and imem_addr=PC.
REQ-019a FETCH, imem_ack=1, no stall, no redirect: Instruction<=imem_rdata, PC_plus4<=PC+4, if_valid<=1, PC<=PC+4. Back-to-back acks give one instruction per cycle.
REQ-020 FETCH, imem_ack=0, no stall: Instruction<=32'h0 (NOP), if_valid<=0. Bubble inserted.
REQ-021 stall=1 and no redirect: Instruction, PC_plus4 and if_valid hold, in every state.
REQ-022 Redirect target: branch_taken gives branch_target. Jump gives {PC_plus4[31:28], jump_index, 2'b00}, using the registered PC_plus4. If both are asserted, branch_taken wins.
REQ-023 Redirect has priority over stall. It applies in every state:
- IF/ID flushed to NOP, if_valid<=0.
- PC<=target.
- HOLD buffer discarded.
REQ-024 Redirect in FETCH with imem_ack=0: go to DRAIN. imem_req stays 1 and imem_addr keeps the old address until ack. That ack is discarded, then go to FETCH at the new PC.
REQ-025 Redirect in FETCH with imem_ack=1: rdata is discarded. Stay in FETCH and present the target next cycle.
REQ-026 A redirect arriving in DRAIN overwrites PC. DRAIN continues until its ack.
REQ-027 PC arithmetic is modulo 2^32: PC 32'hFFFF_FFFC + 4 wraps to 32'h0.
REQ-028 imem_addr[1:0] is always 2'b00.

Reset
REQ-029 While rst=1, on each clock edge:
- PC<=RESET_PC.
- Instruction<=0, PC_plus4<=0, if_valid<=0.
- state<=FETCH, HOLD buffer cleared.
REQ-030 During the rst=1 cycle, imem_req=0. In the first cycle after rst falls, imem_req=1 with imem_addr=RESET_PC.
REQ-031 Reset mid-request abandons the outstanding request. The memory model drops a pending ack on rst.

Configuration
REQ-032 Macro IFETCH_PREFETCH_BUF_EN.
- Defined: imem_ack with stall=1 captures rdata into a one-entry buffer and moves to HOLD. imem_req=0 in HOLD. When stall falls, the buffer loads into IF/ID, PC<=PC+4, and the state returns to FETCH.
- Undefined: imem_ack with stall=1 discards rdata. PC is unchanged and FETCH re-requests the same address. HOLD is unreachable and no buffer is built.

Structure
REQ-033 Shared package mips_pkg holds:
- NOP word 32'h0.
- State encoding for FETCH/HOLD/DRAIN.
- The default reset PC constant.
REQ-034 A single sub-module pc_next_sel is natural: a combinational next-PC select over PC+4, branch, jump and hold. FSM and IF/ID register stay in ifetch.

Verification
REQ-035 Reset release, imem_ack every cycle: imem_addr sequence 0,4,8,C. Instruction follows with one-cycle lag, if_valid=1 from the second cycle.
REQ-036 imem_ack every third cycle: if_valid pattern 0,0,1 repeats, Instruction=0 on bubbles.
REQ-037 stall=1 for 3 cycles while ack arrives for PC=0x10:
- With macro: HOLD entered, word 0x10 appears the cycle after stall falls, no second request to 0x10.
- Without macro: 0x10 re-requested after stall falls.
REQ-038 branch_taken=1, branch_target=0x100, while a request to 0x20 is pending with no ack:
- DRAIN is entered and the ack for 0x20 is dropped.
- Next request is 0x100 and IF/ID=NOP.
REQ-039 branch_taken and Jump together with stall=1, PC_plus4=0x4000_0008, jump_index=0x10: PC becomes branch_target, not 0x4000_0040. The flush overrides stall.
REQ-040 PC=0xFFFF_FFFC fetched, then rst asserted mid-request:
- PC_plus4=0x0 after the wrap.
- After reset, imem_addr=RESET_PC and the stale ack is ignored.
